// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared op encodings and state type for the HI/LO multiply/divide unit
package cpu_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } md_state_t;

endpackage

// File: rtl/md_step.sv
// rtl/md_step.sv - one combinational shift-add multiply or restoring divide iteration
module md_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0]   opd,
    output logic [2*WIDTH-1:0] acc_out,
    output logic               q_bit
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    always_comb begin
        sum     = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, opd} : '0);
        rem_sh  = acc_in[2*WIDTH-1:WIDTH-1];
        diff    = rem_sh - {1'b0, opd};
        q_bit   = 1'b0;
        acc_out = '0;
        if (is_div) begin
            // Quotient bit is returned separately; the vacated LSB is left at zero.
            q_bit = ~diff[WIDTH];
            if (q_bit) begin
                acc_out = {diff[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
            end else begin
                acc_out = {rem_sh[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_out = {sum, acc_in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - multicycle MULT/DIV unit owning the HI and LO registers
module hilo_muldiv_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             hi_write,
    input  logic             lo_write,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    md_state_t          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]   opd_q, opd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               div_zero_q, div_zero_d;

    logic               op_signed;
    logic               op_div;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [2*WIDTH-1:0] step_acc;
    logic               step_q;
    logic [2*WIDTH-1:0] prod;

    md_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div_q),
        .acc_in  (acc_q),
        .opd     (opd_q),
        .acc_out (step_acc),
        .q_bit   (step_q)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        opd_d      = opd_q;
        acc_d      = acc_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;

        op_signed = (op == MD_MULT) || (op == MD_DIV);
        op_div    = (op == MD_DIV) || (op == MD_DIVU);
        abs_a     = (op_signed && a_in[WIDTH-1]) ? -a_in : a_in;
        abs_b     = (op_signed && b_in[WIDTH-1]) ? -b_in : b_in;
        prod      = neg_res_q ? -acc_q : acc_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (op_div && (b_in == '0)) begin
                        done_d     = 1'b1;
                        div_zero_d = 1'b1;
                    end else begin
                        state_d   = RUN;
                        cnt_d     = CNT_W'(WIDTH - 1);
                        is_div_d  = op_div;
                        neg_res_d = op_signed && (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
                        neg_rem_d = op_signed && a_in[WIDTH-1];
                        // Divide shifts the dividend through; multiply shifts the multiplier.
                        if (op_div) begin
                            acc_d = {{WIDTH{1'b0}}, abs_a};
                            opd_d = abs_b;
                        end else begin
                            acc_d = {{WIDTH{1'b0}}, abs_b};
                            opd_d = abs_a;
                        end
                    end
                end else begin
                    if (hi_write) hi_d = hi_in;
                    if (lo_write) lo_d = lo_in;
                end
            end
            RUN: begin
                acc_d = {step_acc[2*WIDTH-1:1], step_acc[0] | step_q};
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (is_div_q) begin
                    lo_d = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    hi_d = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                end else begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            opd_q      <= '0;
            acc_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            opd_q      <= opd_d;
            acc_q      <= acc_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi_out   = hi_q;
    assign lo_out   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb/tb_hilo_muldiv_unit.sv - scoreboard bench for hilo_muldiv_unit
module tb_hilo_muldiv_unit;
    import cpu_pkg::*;

    localparam int W = 32;

    typedef struct packed {
        logic         dz;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         hi_write = 1'b0;
    logic         lo_write = 1'b0;
    logic [W-1:0] hi_in = '0;
    logic [W-1:0] lo_in = '0;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi_out;
    logic [W-1:0] lo_out;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];
    logic [W-1:0] model_hi = '0;
    logic [W-1:0] model_lo = '0;

    hilo_muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a_in     (a_in),
        .b_in     (b_in),
        .hi_write (hi_write),
        .lo_write (lo_write),
        .hi_in    (hi_in),
        .lo_in    (lo_in),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi_out   (hi_out),
        .lo_out   (lo_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        logic [63:0] p;
        longint      sa, sb, q, r;
        e.dz = 1'b0;
        e.hi = model_hi;
        e.lo = model_lo;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if ((o == MD_DIV || o == MD_DIVU) && b == '0) begin
            e.dz = 1'b1;
        end else begin
            case (o)
                MD_MULT:  begin p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; end
                MD_MULTU: begin p = {32'b0, a} * {32'b0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
                MD_DIV:   begin q = sa / sb; r = sa % sb; e.lo = q[31:0]; e.hi = r[31:0]; end
                default:  begin e.lo = a / b; e.hi = a % b; end
            endcase
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (done) begin
                if (sb_q.size() == 0) begin
                    check("done_without_pending_op", 64'(sb_q.size()), 64'd1);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("hi_result", 64'(hi_out), 64'(e.hi));
                    check("lo_result", 64'(lo_out), 64'(e.lo));
                    check("div_zero_flag", 64'(div_zero), 64'(e.dz));
                    check("done_while_busy", 64'(busy), 64'd0);
                end
            end else if (div_zero) begin
                check("div_zero_without_done", 64'(div_zero), 64'd0);
            end
        end
    end

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit interfere);
        exp_t e;
        int   busy_cnt;
        bit   seen;
        e = model(o, a, b);
        sb_q.push_back(e);
        model_hi = e.hi;
        model_lo = e.lo;
        @(negedge clk);
        start = 1'b1; op = o; a_in = a; b_in = b;
        @(negedge clk);
        start = 1'b0; a_in = $urandom; b_in = $urandom;
        busy_cnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            if (interfere) begin
                start    = (i == 3);
                op       = MD_DIVU;
                b_in     = '0;
                lo_write = (i >= 3 && i < 20);
                lo_in    = 32'h0000_DEAD;
            end
            @(negedge clk);
        end
        start = 1'b0;
        lo_write = 1'b0;
        check("done_seen", 64'(seen), 64'd1);
        check("busy_cycles", 64'(busy_cnt), e.dz ? 64'd0 : 64'd33);
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);
        check("div_zero_one_cycle", 64'(div_zero), 64'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_div_zero", 64'(div_zero), 64'd0);
        check("reset_hi", 64'(hi_out), 64'd0);
        check("reset_lo", 64'(lo_out), 64'd0);

        run_op(MD_MULT,  32'hFFFF_FFFD, 32'd5, 1'b0);
        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
        run_op(MD_MULT,  32'hFFFF_FFFF, 32'd2, 1'b0);
        run_op(MD_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

        @(negedge clk);
        hi_write = 1'b1; hi_in = 32'h11;
        lo_write = 1'b1; lo_in = 32'h22;
        @(negedge clk);
        hi_write = 1'b0; lo_write = 1'b0;
        model_hi = 32'h11; model_lo = 32'h22;
        check("mthi", 64'(hi_out), 64'h11);
        check("mtlo", 64'(lo_out), 64'h22);
        run_op(MD_DIVU, 32'd100, 32'd0, 1'b0);
        check("dz_hi_kept", 64'(hi_out), 64'h11);
        check("dz_lo_kept", 64'(lo_out), 64'h22);

        @(negedge clk);
        start = 1'b1; op = MD_MULTU; a_in = 32'h1234_5678; b_in = 32'h9ABC_DEF0;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_hi = '0; model_lo = '0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hi", 64'(hi_out), 64'd0);
        check("abort_lo", 64'(lo_out), 64'd0);
        run_op(MD_DIVU, 32'd100, 32'd7, 1'b0);

        run_op(MD_MULTU, 32'h0001_2345, 32'h0000_0777, 1'b1);

        for (int k = 0; k < 8; k++) begin
            logic [1:0]   ro;
            logic [W-1:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if (k == 7) rb = 32'hFFFF_FFFF;
            if (rb == '0) rb = 32'd3;
            run_op(ro, ra, rb, 1'b0);
        end

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
